// File: rtl/minv_mdiv_pkg.sv
// Shared definitions for the modular inverse / division sequencer:
// state encoding, default sizing and small decode helpers.
package minv_mdiv_pkg;

    localparam int DATA_W        = 32;
    localparam int WORDS_DEFAULT = 8;
    localparam int TO_W_DEFAULT  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOADP = 3'd1,
        ST_LOADA = 3'd2,
        ST_LOADB = 3'd3,
        ST_START = 3'd4,
        ST_WAIT  = 3'd5,
        ST_READ  = 3'd6
    } state_t;

    function automatic logic is_load(input state_t s);
        return (s == ST_LOADP) || (s == ST_LOADA) || (s == ST_LOADB);
    endfunction

endpackage

// File: rtl/minv_mdiv_seq_if.sv
// Host-side request/operand/result bus of the sequencer; the host is the master.
interface minv_mdiv_seq_if;
    import minv_mdiv_pkg::*;

    logic              req;
    logic              op;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output req, op, din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, busy, done, err
    );

    modport slave (
        input  req, op, din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, busy, done, err
    );

endinterface

// File: rtl/minv_mdiv_wcnt.sv
// Word counter shared by the load and read phases; wraps to zero on the
// terminal-count word so each phase starts from a clean count.
module minv_mdiv_wcnt #(
    parameter int WORDS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int            CW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    logic [CW-1:0] cnt;

    assign tc = (cnt == LAST);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/minv_mdiv_seq.sv
// Sequencer that streams p, a (and b for division) into a modular
// inverse/division core, starts it, and streams the selected result back.
module minv_mdiv_seq
    import minv_mdiv_pkg::*;
#(
    parameter int WORDS = WORDS_DEFAULT,
    parameter int TO_W  = TO_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    minv_mdiv_seq_if.slave    bus,

    output logic [DATA_W-1:0] core_datain,
    output logic              core_loadp,
    output logic              core_loada,
    output logic              core_loadb,
    output logic              core_minv_mdiv,
    output logic              core_en,
    output logic              core_outx1,
    output logic              core_outx2,
    input  logic              core_rdy,
    input  logic              core_flag,
    input  logic [DATA_W-1:0] core_x1out,
    input  logic [DATA_W-1:0] core_x2out
);

    localparam logic [TO_W-1:0] WD_MAX = '1;

    state_t          state;
    logic            op_q;
    logic            flag_q;
    logic [TO_W-1:0] wdog;
    logic [TO_W-1:0] wd_next;
    logic            done_q;
    logic            err_q;

    logic            load_fire;
    logic            read_fire;
    logic            wc_tc;

    assign load_fire = is_load(state) && bus.din_valid;
    assign read_fire = (state == ST_READ) && bus.dout_ready;
    assign wd_next   = wdog + 1'b1;

    minv_mdiv_wcnt #(.WORDS(WORDS)) u_wcnt (
        .clk (clk),
        .rst (rst),
        .clr (state == ST_IDLE),
        .inc (load_fire || read_fire),
        .tc  (wc_tc)
    );

    // Host-side status decodes straight from the registered state.
    assign bus.din_ready  = is_load(state);
    assign bus.dout_valid = (state == ST_READ);
    assign bus.dout       = (state == ST_READ) ? (flag_q ? core_x2out : core_x1out) : '0;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;

    assign core_minv_mdiv = (state != ST_IDLE) && op_q;
    assign core_en        = (state == ST_START);

    // Strobes follow the handshake in the same cycle so the core sees each
    // word exactly once, with no strobe while the host stalls.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case leaves a signal unassigned and infers a latch.
        core_datain = '0;
        core_loadp  = 1'b0;
        core_loada  = 1'b0;
        core_loadb  = 1'b0;
        core_outx1  = 1'b0;
        core_outx2  = 1'b0;
        if (load_fire) begin
            core_datain = bus.din;
        end
        case (state)
            ST_LOADP: core_loadp = bus.din_valid;
            ST_LOADA: core_loada = bus.din_valid;
            ST_LOADB: core_loadb = bus.din_valid;
            ST_READ: begin
                core_outx1 = read_fire && !flag_q;
                core_outx2 = read_fire &&  flag_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            op_q   <= 1'b0;
            flag_q <= 1'b0;
            wdog   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // Zero while in START, so it counts cycles elapsed since core_en.
            wdog   <= ((state == ST_START) || (state == ST_WAIT)) ? wd_next : '0;

            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        op_q  <= bus.op;
                        state <= ST_LOADP;
                    end
                end
                ST_LOADP: begin
                    if (load_fire && wc_tc) state <= ST_LOADA;
                end
                ST_LOADA: begin
                    if (load_fire && wc_tc) state <= op_q ? ST_START : ST_LOADB;
                end
                ST_LOADB: begin
                    if (load_fire && wc_tc) state <= ST_START;
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_rdy) begin
                        flag_q <= core_flag;
                        state  <= ST_READ;
                    end else if (wd_next == WD_MAX) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (read_fire && wc_tc) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minv_mdiv_seq.sv
// Directed bench for minv_mdiv_seq with a small behavioural core model.
module tb_minv_mdiv_seq;
    import minv_mdiv_pkg::*;

    localparam int WORDS = 8;
    localparam int TO_W  = 4;
    localparam int LAT   = 3;

    // Event indices tracked by the monitor.
    localparam int E_LP = 0, E_LA = 1, E_LB = 2, E_EN = 3, E_X1 = 4, E_X2 = 5, E_DONE = 6, E_ERR = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    minv_mdiv_seq_if bus();

    logic [31:0] core_datain;
    logic        core_loadp, core_loada, core_loadb, core_minv_mdiv, core_en, core_outx1, core_outx2;
    logic        core_rdy = 1'b0;
    logic        core_flag;
    logic [31:0] core_x1out, core_x2out;

    minv_mdiv_seq #(.WORDS(WORDS), .TO_W(TO_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .core_datain    (core_datain),
        .core_loadp     (core_loadp),
        .core_loada     (core_loada),
        .core_loadb     (core_loadb),
        .core_minv_mdiv (core_minv_mdiv),
        .core_en        (core_en),
        .core_outx1     (core_outx1),
        .core_outx2     (core_outx2),
        .core_rdy       (core_rdy),
        .core_flag      (core_flag),
        .core_x1out     (core_x1out),
        .core_x2out     (core_x2out)
    );

    // ---------------- core model ----------------
    logic [31:0] x1_mem [WORDS];
    logic [31:0] x2_mem [WORDS];
    bit          rdy_enable = 1'b1;
    bit          flag_cfg   = 1'b0;
    int          lat_cnt    = 0;
    int          rd_idx     = 0;

    assign core_flag  = flag_cfg;
    assign core_x1out = x1_mem[rd_idx % WORDS];
    assign core_x2out = x2_mem[rd_idx % WORDS];

    always @(posedge clk) begin
        core_rdy <= 1'b0;
        if (core_en) begin
            lat_cnt <= LAT;
            rd_idx  <= 0;
        end else begin
            if (lat_cnt > 0) begin
                lat_cnt <= lat_cnt - 1;
                if (lat_cnt == 1 && rdy_enable) core_rdy <= 1'b1;
            end
            if (core_outx1 || core_outx2) rd_idx <= rd_idx + 1;
        end
    end

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            cnt [8];
    int            snap_cnt [8];
    int            first_c [8];
    int            last_c [8];
    logic [255:0]  cap [3];
    int            n_viol = 0;
    int            snap_viol = 0;
    logic          exp_op = 1'b0;
    logic [7:0]    ev;
    int            n_str;

    initial begin
        for (int i = 0; i < 8; i++) begin
            cnt[i] = 0; first_c[i] = 0; last_c[i] = 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        ev = {bus.err, bus.done, core_outx2, core_outx1, core_en, core_loadb, core_loada, core_loadp};
        n_str = int'(core_loadp) + int'(core_loada) + int'(core_loadb) + int'(core_outx1) + int'(core_outx2);
        if (n_str > 1) n_viol++;
        if (!bus.busy && (n_str != 0 || core_en)) n_viol++;
        if ((core_loadp || core_loada || core_loadb) && !bus.din_valid) n_viol++;
        if ((core_outx1 || core_outx2) && !bus.dout_ready) n_viol++;
        if (bus.busy && (core_minv_mdiv !== exp_op)) n_viol++;
        if (!bus.busy && core_minv_mdiv) n_viol++;
        for (int t = 0; t < 8; t++) begin
            if (ev[t]) begin
                if (cnt[t] == snap_cnt[t]) first_c[t] = cyc;
                last_c[t] = cyc;
                if (t < 3) cap[t][32*((cnt[t] - snap_cnt[t]) % WORDS) +: 32] = core_datain;
                cnt[t]++;
            end
        end
    end

    // ---------------- bench state ----------------
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  vec_p [WORDS];
    logic [31:0]  vec_a [WORDS];
    logic [31:0]  vec_b [WORDS];
    logic [255:0] got_res;

    function automatic logic [63:0] deltas();
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[63-8*i -: 8] = 8'(cnt[i] - snap_cnt[i]);
        return d;
    endfunction

    function automatic logic [75:0] outs_vec();
        return {bus.busy, bus.done, bus.err, bus.din_ready, bus.dout_valid, bus.dout, core_datain,
                core_loadp, core_loada, core_loadb, core_minv_mdiv, core_en, core_outx1, core_outx2};
    endfunction

    task automatic snap();
        for (int i = 0; i < 8; i++) snap_cnt[i] = cnt[i];
        snap_viol = n_viol;
        for (int i = 0; i < 3; i++) cap[i] = '0;
    endtask

    task automatic set_operands(input logic [31:0] p0, input logic [31:0] a0, input logic [31:0] b0);
        for (int i = 0; i < WORDS; i++) begin
            vec_p[i] = (i == 0) ? p0 : 32'h0;
            vec_a[i] = (i == 0) ? a0 : 32'h0;
            vec_b[i] = (i == 0) ? b0 : 32'h0;
        end
    endtask

    task automatic set_result(input logic [31:0] r0, input bit on_x2);
        for (int i = 0; i < WORDS; i++) begin
            x1_mem[i] = on_x2 ? (32'hDEAD_0000 + 32'(i)) : ((i == 0) ? r0 : 32'h0);
            x2_mem[i] = on_x2 ? ((i == 0) ? r0 : 32'h0) : (32'hBEEF_0000 + 32'(i));
        end
    endtask

    task automatic start_op(input logic op_i);
        exp_op = op_i;
        @(posedge clk); #1;
        bus.op  = op_i;
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        bus.op  = 1'b0;
    endtask

    task automatic load_stream(input int which, input int nwords, input bit toggle, output bit ok);
        int k;
        ok = 1'b1;
        for (int i = 0; i < nwords; i++) begin
            if (toggle) begin
                bus.din_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.din       = (which == 0) ? vec_p[i] : (which == 1) ? vec_a[i] : vec_b[i];
            bus.din_valid = 1'b1;
            k = 0;
            while (!bus.din_ready && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            if (!bus.din_ready) ok = 1'b0;
            @(posedge clk); #1;
            bus.din_valid = 1'b0;
            bus.din       = '0;
        end
    endtask

    task automatic read_result(input int stall_at);
        for (int i = 0; i < WORDS; i++) begin
            if (i == stall_at) begin
                repeat (5) begin @(posedge clk); #1; end
            end
            got_res[32*i +: 32] = bus.dout;
            bus.dout_ready = 1'b1;
            @(posedge clk); #1;
            bus.dout_ready = 1'b0;
        end
    endtask

    task automatic run_op(input logic op_i, input bit toggle, input int stall_at, output bit ok);
        bit o1, o2, o3;
        int k;
        got_res = 'x;
        start_op(op_i);
        load_stream(0, WORDS, toggle, o1);
        load_stream(1, WORDS, toggle, o2);
        o3 = 1'b1;
        if (!op_i) load_stream(2, WORDS, toggle, o3);
        k = 0;
        while (!bus.dout_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        ok = o1 && o2 && o3 && bus.dout_valid;
        if (ok) read_result(stall_at);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.req = 1'b1; bus.op = 1'b1; bus.din = 32'hFFFF_FFFF; bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", outs_vec());
        end
        bus.req = 1'b0; bus.op = 1'b0; bus.din = '0; bus.din_valid = 1'b0; bus.dout_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs_vec() !== '0) begin
            errors++;
            $display("FAIL idle_after_reset got=%h want=0", outs_vec());
        end
    endtask

    task automatic test_inverse(input string tag);
        bit ok;
        set_operands(32'd23, 32'd3, 32'd0);
        set_result(32'd8, 1'b0);
        flag_cfg = 1'b0;
        snap();
        run_op(1'b1, 1'b0, -1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_handshake_timeout got=0 want=1", tag); end
        checks++;
        if (got_res !== 256'd8) begin errors++; $display("FAIL %s_result got=%h want=%h", tag, got_res, 256'd8); end
        checks++;
        if (deltas() !== 64'h0808_0001_0800_0100) begin
            errors++; $display("FAIL %s_strobe_counts got=%h want=%h", tag, deltas(), 64'h0808_0001_0800_0100);
        end
        checks++;
        if (cap[0] !== 256'd23 || cap[1] !== 256'd3) begin
            errors++; $display("FAIL %s_loaded_pa got p=%h a=%h want p=23 a=3", tag, cap[0], cap[1]);
        end
        checks++;
        if (!(last_c[E_LP] < first_c[E_LA] && last_c[E_LA] < first_c[E_EN])) begin
            errors++; $display("FAIL %s_load_order got lastp=%0d firsta=%0d lasta=%0d en=%0d want increasing",
                               tag, last_c[E_LP], first_c[E_LA], last_c[E_LA], first_c[E_EN]);
        end
        checks++;
        if (n_viol != snap_viol || bus.busy !== 1'b0) begin
            errors++; $display("FAIL %s_protocol got viol=%0d busy=%b want 0 0", tag, n_viol - snap_viol, bus.busy);
        end
    endtask

    task automatic test_division(input string tag, input bit toggle, input int stall_at);
        bit ok;
        set_operands(32'd23, 32'd3, 32'd5);
        set_result(32'd17, 1'b0);
        flag_cfg = 1'b0;
        snap();
        run_op(1'b0, toggle, stall_at, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_handshake_timeout got=0 want=1", tag); end
        checks++;
        if (got_res !== 256'd17) begin errors++; $display("FAIL %s_result got=%h want=%h", tag, got_res, 256'd17); end
        checks++;
        if (deltas() !== 64'h0808_0801_0800_0100) begin
            errors++; $display("FAIL %s_strobe_counts got=%h want=%h", tag, deltas(), 64'h0808_0801_0800_0100);
        end
        checks++;
        if (cap[0] !== 256'd23 || cap[1] !== 256'd3 || cap[2] !== 256'd5) begin
            errors++; $display("FAIL %s_loaded_pab got p=%h a=%h b=%h want 23 3 5", tag, cap[0], cap[1], cap[2]);
        end
        checks++;
        if (!(last_c[E_LP] < first_c[E_LA] && last_c[E_LA] < first_c[E_LB] && last_c[E_LB] < first_c[E_EN])) begin
            errors++; $display("FAIL %s_load_order got lastp=%0d firsta=%0d lasta=%0d firstb=%0d want increasing",
                               tag, last_c[E_LP], first_c[E_LA], last_c[E_LA], first_c[E_LB]);
        end
        checks++;
        if (n_viol != snap_viol) begin
            errors++; $display("FAIL %s_protocol got viol=%0d want=0", tag, n_viol - snap_viol);
        end
    endtask

    task automatic test_flag_routing();
        bit ok;
        set_operands(32'd23, 32'd3, 32'd0);
        set_result(32'd8, 1'b1);
        flag_cfg = 1'b1;
        snap();
        run_op(1'b1, 1'b0, -1, ok);
        flag_cfg = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL flag_handshake_timeout got=0 want=1"); end
        checks++;
        if (got_res !== 256'd8) begin errors++; $display("FAIL flag_result got=%h want=%h", got_res, 256'd8); end
        checks++;
        if (deltas() !== 64'h0808_0001_0008_0100) begin
            errors++; $display("FAIL flag_strobe_counts got=%h want=%h", deltas(), 64'h0808_0001_0008_0100);
        end
    endtask

    task automatic test_timeout();
        bit o1, o2;
        int k;
        set_operands(32'd23, 32'd3, 32'd0);
        rdy_enable = 1'b0;
        snap();
        start_op(1'b1);
        load_stream(0, WORDS, 1'b0, o1);
        load_stream(1, WORDS, 1'b0, o2);
        k = 0;
        while (!bus.err && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL timeout_err_seen got=%b want=1", bus.err); end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL timeout_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        repeat (2) begin @(posedge clk); #1; end
        rdy_enable = 1'b1;
        checks++;
        if (first_c[E_ERR] - first_c[E_EN] != 15) begin
            errors++; $display("FAIL timeout_latency got=%0d want=15", first_c[E_ERR] - first_c[E_EN]);
        end
        checks++;
        if (deltas() !== 64'h0808_0001_0000_0001) begin
            errors++; $display("FAIL timeout_counts got=%h want=%h", deltas(), 64'h0808_0001_0000_0001);
        end
        checks++;
        if (!(o1 && o2) || n_viol != snap_viol) begin
            errors++; $display("FAIL timeout_protocol got ok=%b viol=%0d want 1 0", o1 && o2, n_viol - snap_viol);
        end
    endtask

    task automatic test_midop_reset();
        bit o1, o2;
        set_operands(32'd23, 32'd3, 32'd0);
        snap();
        start_op(1'b1);
        load_stream(0, WORDS, 1'b0, o1);
        load_stream(1, 4, 1'b0, o2);
        bus.din       = 32'h1234_5678;
        bus.din_valid = 1'b1;
        checks++;
        if (core_loada !== 1'b1 || bus.din_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_in_loada got loada=%b ready=%b want 1 1", core_loada, bus.din_ready);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (outs_vec() !== '0) begin errors++; $display("FAIL midrst_outputs got=%h want=0", outs_vec()); end
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        checks++;
        if (outs_vec() !== '0) begin errors++; $display("FAIL midrst_held got=%h want=0", outs_vec()); end
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (deltas() !== 64'h0804_0000_0000_0000 || !(o1 && o2)) begin
            errors++; $display("FAIL midrst_counts got=%h want=%h", deltas(), 64'h0804_0000_0000_0000);
        end
        test_inverse("after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.req = 1'b0; bus.op = 1'b0; bus.din = '0; bus.din_valid = 1'b0; bus.dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) cap[i] = '0;
        test_reset();
        test_inverse("inverse");
        test_division("division", 1'b0, -1);
        test_division("backpressure", 1'b1, 3);
        test_flag_routing();
        test_timeout();
        test_midop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
